// File: rtl/i2c_target.sv
// I2C target (slave) responder with a 7-bit address.
// SCL/SDA are synchronized and glitch-filtered on the system clock, START/STOP
// and SCL edges are derived from the filtered levels, and a byte-level FSM
// ACKs its own address, hands written bytes out and sources read bytes through
// one-cycle strobes. SDA is open-drain (0 = pull low); SCL is never driven.
module i2c_target #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [6:0] own_addr_i,
  input  logic       i2c_sclk_i,
  input  logic       i2c_sdat_i,
  output logic       i2c_sdat_o,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       rx_full_i,
  input  logic [7:0] data_i,
  input  logic       data_available_i,
  output logic       data_read_o,
  output logic       rw_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA through the input path.
  logic [1:0] line_raw;
  logic [1:0] line_filt;
  logic [1:0] line_rise;
  logic [1:0] line_fall;

  assign line_raw = {i2c_sdat_i, i2c_sclk_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [FCW-1:0]         cnt_reg;
      logic                   filt_reg;
      logic                   rise_reg;
      logic                   fall_reg;
      logic                   sync_out;

      assign sync_out = sync_reg[SYNC_STAGES-1];

      // Synchronizer chain; resets to 1 so an idle bus produces no edges.
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) sync_reg <= '1;
        else         sync_reg <= (sync_reg << 1) | SYNC_STAGES'(line_raw[gi]);
      end

      // Accept a new level only after FILTER_LEN consecutive differing samples;
      // the edge pulses are emitted in the same cycle the level flips.
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          filt_reg <= 1'b1;
          cnt_reg  <= '0;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (sync_out == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == FCW'(FILTER_LEN - 1)) begin
            filt_reg <= sync_out;
            cnt_reg  <= '0;
            rise_reg <= sync_out;
            fall_reg <= ~sync_out;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign line_filt[gi] = filt_reg;
      assign line_rise[gi] = rise_reg;
      assign line_fall[gi] = fall_reg;
    end
  endgenerate

  logic scl_rise, scl_fall, sda_bit, start_det, stop_det;
  assign scl_rise  = line_rise[0];
  assign scl_fall  = line_fall[0];
  assign sda_bit   = line_filt[1];
  assign start_det = line_fall[1] & line_filt[0];
  assign stop_det  = line_rise[1] & line_filt[0];

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shreg_reg, shreg_next;
  logic       sda_reg, sda_next;
  logic       rw_reg, rw_next;
  logic       phase_reg, phase_next;    // ACK phase: driven / controller ACKed
  logic       accept_reg, accept_next;  // last written byte was taken
  logic [7:0] data_reg, data_next;
  logic       valid_reg, valid_next;
  logic       read_reg, read_next;
  logic       start_reg, start_next;
  logic       stop_reg, stop_next;
  logic [7:0] load_byte;

  assign load_byte = data_available_i ? data_i : 8'hFF;
  assign busy_o    = (state_reg == ADDR_ACK) || (state_reg == WR_DATA) ||
                     (state_reg == WR_ACK)   || (state_reg == RD_DATA) ||
                     (state_reg == RD_ACK);

  // Next-state and output logic; STOP beats START beats SCL edges.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    sda_next     = sda_reg;
    rw_next      = rw_reg;
    phase_next   = phase_reg;
    accept_next  = accept_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    read_next    = 1'b0;
    start_next   = 1'b0;
    stop_next    = 1'b0;
    if (stop_det) begin
      state_next = IDLE;
      sda_next   = 1'b1;
      stop_next  = busy_o;
    end else if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = 3'd0;
      sda_next     = 1'b1;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shreg_next   = {shreg_reg[6:0], sda_bit};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if ((shreg_reg[6:0] == own_addr_i) && (own_addr_i != 7'h00)) begin
                state_next = ADDR_ACK;
                rw_next    = sda_bit;
                start_next = 1'b1;
                phase_next = 1'b0;
              end else begin
                state_next = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              sda_next   = 1'b0;
              phase_next = 1'b1;
            end else begin
              bit_cnt_next = 3'd0;
              if (rw_reg) begin
                read_next  = 1'b1;
                shreg_next = load_byte;
                sda_next   = load_byte[7];
                state_next = RD_DATA;
              end else begin
                sda_next   = 1'b1;
                state_next = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_next   = {shreg_reg[6:0], sda_bit};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_next  = WR_ACK;
              phase_next  = 1'b0;
              accept_next = ~rx_full_i;
              if (!rx_full_i) begin
                data_next  = {shreg_reg[6:0], sda_bit};
                valid_next = 1'b1;
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              sda_next   = ~accept_reg;
              phase_next = 1'b1;
            end else begin
              sda_next     = 1'b1;
              bit_cnt_next = 3'd0;
              state_next   = accept_reg ? WR_DATA : IGNORE;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 3'd7) begin
              sda_next   = 1'b1;
              phase_next = 1'b0;
              state_next = RD_ACK;
            end else begin
              shreg_next   = {shreg_reg[6:0], 1'b0};
              sda_next     = shreg_reg[6];
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_bit) state_next = IGNORE;
            else         phase_next = 1'b1;
          end else if (scl_fall && phase_reg) begin
            read_next    = 1'b1;
            shreg_next   = load_byte;
            sda_next     = load_byte[7];
            bit_cnt_next = 3'd0;
            state_next   = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      shreg_reg   <= 8'h00;
      sda_reg     <= 1'b1;
      rw_reg      <= 1'b0;
      phase_reg   <= 1'b0;
      accept_reg  <= 1'b0;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      read_reg    <= 1'b0;
      start_reg   <= 1'b0;
      stop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      sda_reg     <= sda_next;
      rw_reg      <= rw_next;
      phase_reg   <= phase_next;
      accept_reg  <= accept_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      read_reg    <= read_next;
      start_reg   <= start_next;
      stop_reg    <= stop_next;
    end
  end

  assign i2c_sdat_o   = sda_reg;
  assign data_o       = data_reg;
  assign data_valid_o = valid_reg;
  assign data_read_o  = read_reg;
  assign rw_o         = rw_reg;
  assign start_o      = start_reg;
  assign stop_o       = stop_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a behavioural bus controller drives SCL/SDA
// (wired-AND with the target's SDA) and each scenario checks its own results.
module tb_i2c_target;

  localparam int Q = 10;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] own_addr = 7'h2D;
  logic       scl = 1'b1;
  logic       ctrl_sda = 1'b1;
  wire        dut_sda;
  wire        sda_bus;
  wire [7:0]  data_o;
  wire        data_valid, data_read, rw, start_p, stop_p, busy;
  logic       rx_full = 1'b0;
  logic [7:0] data_i;
  logic       data_avail = 1'b1;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int n_valid = 0, n_read = 0, n_start = 0, n_stop = 0, n_sda_low = 0;
  int rd_base = 0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00;

  assign sda_bus = ctrl_sda & dut_sda;
  assign data_i  = (n_read == rd_base) ? tx0 : tx1;

  always #5 clk = ~clk;

  i2c_target dut (
    .clock_i(clk), .reset_i(rst), .own_addr_i(own_addr),
    .i2c_sclk_i(scl), .i2c_sdat_i(sda_bus), .i2c_sdat_o(dut_sda),
    .data_o(data_o), .data_valid_o(data_valid), .rx_full_i(rx_full),
    .data_i(data_i), .data_available_i(data_avail), .data_read_o(data_read),
    .rw_o(rw), .start_o(start_p), .stop_o(stop_p), .busy_o(busy)
  );

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (data_valid) n_valid++;
    if (data_read)  n_read++;
    if (start_p)    n_start++;
    if (stop_p)     n_stop++;
    if (!dut_sda)   n_sda_low++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    ctrl_sda = 1'b1; scl = 1'b1; wait_clks(Q);
    ctrl_sda = 1'b0; wait_clks(Q);
    scl = 1'b0; wait_clks(Q);
  endtask

  task automatic bus_stop();
    ctrl_sda = 1'b0; wait_clks(Q);
    scl = 1'b1; wait_clks(Q);
    ctrl_sda = 1'b1; wait_clks(2 * Q);
  endtask

  // glitch=1 pulls SDA low for one clock in the middle of SCL high.
  task automatic send_bit(input logic b, input logic glitch);
    ctrl_sda = b; wait_clks(Q);
    scl = 1'b1; wait_clks(Q);
    if (glitch) begin
      ctrl_sda = 1'b0; wait_clks(1); ctrl_sda = b; wait_clks(Q - 1);
    end else begin
      wait_clks(Q);
    end
    scl = 1'b0; wait_clks(Q);
  endtask

  task automatic recv_bit(output logic b);
    ctrl_sda = 1'b1; wait_clks(Q);
    scl = 1'b1; wait_clks(Q);
    b = sda_bus; wait_clks(Q);
    scl = 1'b0; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack, 1'b0);
  endtask

  task automatic test_reset();
    wait_clks(3);
    cmp_cnt++; if (dut_sda !== 1'b1) begin err_cnt++; $display("FAIL reset_sda: got %b want 1", dut_sda); end
    cmp_cnt++; if ({data_valid, data_read, rw, start_p, stop_p, busy} !== 6'b0) begin
      err_cnt++; $display("FAIL reset_flags: got %b want 000000", {data_valid, data_read, rw, start_p, stop_p, busy}); end
    cmp_cnt++; if (data_o !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h want 00", data_o); end
    rst = 1'b0;
    wait_clks(20);
    $display("reset released");
  endtask

  task automatic test_write();
    logic a0, a1;
    int v0, s0, p0;
    v0 = n_valid; s0 = n_start; p0 = n_stop;
    bus_start();
    send_byte(8'h5A, -1, a0);
    send_byte(8'hA5, -1, a1);
    cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL wr_busy: got %b want 1", busy); end
    bus_stop();
    $display("write 5A A5: addr_ack=%b data_ack=%b data_o=%h", a0, a1, data_o);
    cmp_cnt++; if (a0 !== 1'b0) begin err_cnt++; $display("FAIL wr_addr_ack: got %b want 0", a0); end
    cmp_cnt++; if (a1 !== 1'b0) begin err_cnt++; $display("FAIL wr_data_ack: got %b want 0", a1); end
    cmp_cnt++; if (n_valid - v0 !== 1) begin err_cnt++; $display("FAIL wr_valid_cnt: got %0d want 1", n_valid - v0); end
    cmp_cnt++; if (data_o !== 8'hA5) begin err_cnt++; $display("FAIL wr_data: got %h want a5", data_o); end
    cmp_cnt++; if (n_start - s0 !== 1) begin err_cnt++; $display("FAIL wr_start_cnt: got %0d want 1", n_start - s0); end
    cmp_cnt++; if (n_stop - p0 !== 1) begin err_cnt++; $display("FAIL wr_stop_cnt: got %0d want 1", n_stop - p0); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    cmp_cnt++; if (rw !== 1'b0) begin err_cnt++; $display("FAIL wr_rw: got %b want 0", rw); end
  endtask

  task automatic test_wrong_addr();
    logic a0;
    int l0, s0, v0, r0, p0;
    l0 = n_sda_low; s0 = n_start; v0 = n_valid; r0 = n_read; p0 = n_stop;
    bus_start();
    send_byte(8'h5C, -1, a0);
    bus_stop();
    $display("address 5C: ack=%b", a0);
    cmp_cnt++; if (a0 !== 1'b1) begin err_cnt++; $display("FAIL na_ack: got %b want 1", a0); end
    cmp_cnt++; if (n_sda_low - l0 !== 0) begin err_cnt++; $display("FAIL na_sda_low: got %0d want 0", n_sda_low - l0); end
    cmp_cnt++; if ((n_start - s0) + (n_valid - v0) + (n_read - r0) + (n_stop - p0) !== 0) begin
      err_cnt++; $display("FAIL na_strobes: got %0d want 0", (n_start - s0) + (n_valid - v0) + (n_read - r0) + (n_stop - p0)); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL na_busy: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] b0, b1;
    int p0;
    rd_base = n_read; tx0 = 8'h3C; tx1 = 8'hC3;
    p0 = n_stop;
    bus_start();
    send_byte(8'h5B, -1, a0);
    cmp_cnt++; if (rw !== 1'b1) begin err_cnt++; $display("FAIL rd_rw: got %b want 1", rw); end
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    wait_clks(Q);
    cmp_cnt++; if (dut_sda !== 1'b1) begin err_cnt++; $display("FAIL rd_release: got %b want 1", dut_sda); end
    bus_stop();
    $display("read 5B: ack=%b bytes=%h %h reads=%0d", a0, b0, b1, n_read - rd_base);
    cmp_cnt++; if (a0 !== 1'b0) begin err_cnt++; $display("FAIL rd_addr_ack: got %b want 0", a0); end
    cmp_cnt++; if (b0 !== 8'h3C) begin err_cnt++; $display("FAIL rd_byte0: got %h want 3c", b0); end
    cmp_cnt++; if (b1 !== 8'hC3) begin err_cnt++; $display("FAIL rd_byte1: got %h want c3", b1); end
    cmp_cnt++; if (n_read - rd_base !== 2) begin err_cnt++; $display("FAIL rd_read_cnt: got %0d want 2", n_read - rd_base); end
    cmp_cnt++; if (n_stop - p0 !== 0) begin err_cnt++; $display("FAIL rd_stop_cnt: got %0d want 0", n_stop - p0); end
  endtask

  task automatic test_rx_full();
    logic a0, a1;
    int v0;
    v0 = n_valid;
    rx_full = 1'b1;
    bus_start();
    send_byte(8'h5A, -1, a0);
    send_byte(8'h11, -1, a1);
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL full_busy: got %b want 0", busy); end
    bus_stop();
    rx_full = 1'b0;
    $display("write 5A 11 full: addr_ack=%b data_ack=%b", a0, a1);
    cmp_cnt++; if (a0 !== 1'b0) begin err_cnt++; $display("FAIL full_addr_ack: got %b want 0", a0); end
    cmp_cnt++; if (a1 !== 1'b1) begin err_cnt++; $display("FAIL full_data_ack: got %b want 1", a1); end
    cmp_cnt++; if (n_valid - v0 !== 0) begin err_cnt++; $display("FAIL full_valid_cnt: got %0d want 0", n_valid - v0); end
    cmp_cnt++; if (data_o !== 8'hA5) begin err_cnt++; $display("FAIL full_data: got %h want a5", data_o); end
  endtask

  task automatic test_glitch();
    logic a0, a1;
    int s0, v0;
    s0 = n_start; v0 = n_valid;
    ctrl_sda = 1'b0; wait_clks(1); ctrl_sda = 1'b1; wait_clks(2 * Q);
    cmp_cnt++; if (n_start - s0 !== 0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL glitch_idle: got starts=%0d busy=%b want 0 0", n_start - s0, busy); end
    bus_start();
    send_byte(8'h5A, -1, a0);
    send_byte(8'hF0, 6, a1);
    bus_stop();
    $display("write 5A F0 with glitch: addr_ack=%b data_ack=%b data_o=%h", a0, a1, data_o);
    cmp_cnt++; if (a1 !== 1'b0) begin err_cnt++; $display("FAIL glitch_ack: got %b want 0", a1); end
    cmp_cnt++; if (data_o !== 8'hF0) begin err_cnt++; $display("FAIL glitch_data: got %h want f0", data_o); end
    cmp_cnt++; if (n_start - s0 !== 1 || n_valid - v0 !== 1) begin
      err_cnt++; $display("FAIL glitch_strobes: got starts=%0d valids=%0d want 1 1", n_start - s0, n_valid - v0); end
  endtask

  task automatic test_reset_mid();
    logic a0, a1;
    int v0;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(8'h5A >> i, 1'b0);
    ctrl_sda = 1'b1;
    for (int i = 0; i < 60 && dut_sda; i++) @(negedge clk);
    cmp_cnt++; if (dut_sda !== 1'b0) begin err_cnt++; $display("FAIL rst_ack_drive: got %b want 0", dut_sda); end
    rst = 1'b1;
    #1;
    cmp_cnt++; if (dut_sda !== 1'b1) begin err_cnt++; $display("FAIL rst_release: got %b want 1", dut_sda); end
    cmp_cnt++; if ({data_valid, data_read, start_p, stop_p, busy} !== 5'b0 || data_o !== 8'h00) begin
      err_cnt++; $display("FAIL rst_flags: got %b data %h want 00000 00", {data_valid, data_read, start_p, stop_p, busy}, data_o); end
    wait_clks(3);
    rst = 1'b0;
    wait_clks(Q);
    bus_stop();
    v0 = n_valid;
    bus_start();
    send_byte(8'h5A, -1, a0);
    send_byte(8'h77, -1, a1);
    bus_stop();
    $display("post-reset write 5A 77: addr_ack=%b data_ack=%b data_o=%h", a0, a1, data_o);
    cmp_cnt++; if ({a0, a1} !== 2'b00) begin err_cnt++; $display("FAIL post_rst_acks: got %b want 00", {a0, a1}); end
    cmp_cnt++; if (data_o !== 8'h77 || n_valid - v0 !== 1) begin
      err_cnt++; $display("FAIL post_rst_data: got %h/%0d want 77/1", data_o, n_valid - v0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_rx_full();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
